// File: rtl/pi_loop_sequencer_if.sv
// Loop-side bundle for pi_loop_sequencer: ADC handshake, pipeline operands/results, DAC handshake, status.
// master = sequencer side, slave = surrounding ADC/DAC/pipeline/control logic.
interface pi_loop_sequencer_if #(
  parameter int INPUT_WIDTH  = 18,
  parameter int OUTPUT_WIDTH = 32,
  parameter int DAC_WIDTH    = 20
);
  logic                    i_enable;
  logic                    i_integral_clear;
  logic                    o_adc_req;
  logic                    i_adc_valid;
  logic [INPUT_WIDTH-1:0]  i_adc_data;
  logic [INPUT_WIDTH-1:0]  o_pipe_actual;
  logic [OUTPUT_WIDTH-1:0] o_pipe_integral;
  logic [OUTPUT_WIDTH-1:0] i_pipe_integral;
  logic [OUTPUT_WIDTH-1:0] i_pipe_out;
  logic                    o_dac_req;
  logic                    i_dac_ready;
  logic [DAC_WIDTH-1:0]    o_dac_data;
  logic                    o_busy;
  logic                    o_timeout;
  logic [31:0]             o_iterations;

  modport master (
    input  i_enable, i_integral_clear, i_adc_valid, i_adc_data,
           i_pipe_integral, i_pipe_out, i_dac_ready,
    output o_adc_req, o_pipe_actual, o_pipe_integral, o_dac_req,
           o_dac_data, o_busy, o_timeout, o_iterations
  );

  modport slave (
    output i_enable, i_integral_clear, i_adc_valid, i_adc_data,
           i_pipe_integral, i_pipe_out, i_dac_ready,
    input  o_adc_req, o_pipe_actual, o_pipe_integral, o_dac_req,
           o_dac_data, o_busy, o_timeout, o_iterations
  );
endinterface

// File: rtl/pi_loop_sequencer.sv
// Sequences one PI loop iteration: ADC sample -> pipeline settle -> clamped integral write-back
// and saturated DAC write. Repeats while enabled; handshake waits are bounded by TIMEOUT.
module pi_loop_sequencer #(
  parameter int INPUT_WIDTH  = 18,
  parameter int OUTPUT_WIDTH = 32,
  parameter int DAC_WIDTH    = 20,
  parameter int OUT_SHIFT    = 12,
  parameter int PIPE_LATENCY = 4,
  parameter int INT_LIMIT    = 2**30 - 1,
  parameter int TIMEOUT      = 1023
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  pi_loop_sequencer_if.master     bus
);

  localparam int CNT_MAX = (TIMEOUT > PIPE_LATENCY) ? TIMEOUT : PIPE_LATENCY;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_ADC_REQ  = 3'd1;
  localparam logic [2:0] S_ADC_WAIT = 3'd2;
  localparam logic [2:0] S_SETTLE   = 3'd3;
  localparam logic [2:0] S_DAC_WAIT = 3'd4;

  localparam logic signed [OUTPUT_WIDTH-1:0] INT_MAX = OUTPUT_WIDTH'(INT_LIMIT);
  localparam logic signed [OUTPUT_WIDTH-1:0] INT_MIN = -INT_MAX;
  localparam logic signed [OUTPUT_WIDTH-1:0] DAC_MAX =
    {{(OUTPUT_WIDTH-DAC_WIDTH+1){1'b0}}, {(DAC_WIDTH-1){1'b1}}};
  localparam logic signed [OUTPUT_WIDTH-1:0] DAC_MIN =
    {{(OUTPUT_WIDTH-DAC_WIDTH+1){1'b1}}, {(DAC_WIDTH-1){1'b0}}};

  logic [2:0]              state_q,    state_d;
  logic [CNT_W-1:0]        cnt_q,      cnt_d;
  logic                    adc_req_q,  adc_req_d;
  logic [INPUT_WIDTH-1:0]  actual_q,   actual_d;
  logic [OUTPUT_WIDTH-1:0] integral_q, integral_d;
  logic                    dac_req_q,  dac_req_d;
  logic [DAC_WIDTH-1:0]    dac_data_q, dac_data_d;
  logic                    timeout_q,  timeout_d;
  logic [31:0]             iter_q,     iter_d;

  logic signed [OUTPUT_WIDTH-1:0] integ_in;
  logic signed [OUTPUT_WIDTH-1:0] integ_clamped;
  logic signed [OUTPUT_WIDTH-1:0] shifted;
  logic [DAC_WIDTH-1:0]           dac_sat;

  always_comb begin
    integ_in = $signed(bus.i_pipe_integral);
    shifted  = $signed(bus.i_pipe_out) >>> OUT_SHIFT;

    if (integ_in > INT_MAX)      integ_clamped = INT_MAX;
    else if (integ_in < INT_MIN) integ_clamped = INT_MIN;
    else                         integ_clamped = integ_in;

    if (shifted > DAC_MAX)       dac_sat = DAC_MAX[DAC_WIDTH-1:0];
    else if (shifted < DAC_MIN)  dac_sat = DAC_MIN[DAC_WIDTH-1:0];
    else                         dac_sat = shifted[DAC_WIDTH-1:0];
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    adc_req_d  = adc_req_q;
    actual_d   = actual_q;
    integral_d = integral_q;
    dac_req_d  = dac_req_q;
    dac_data_d = dac_data_q;
    timeout_d  = timeout_q;
    iter_d     = iter_q;

    case (state_q)
      S_IDLE: begin
        if (bus.i_integral_clear) integral_d = '0;
        if (bus.i_enable) begin
          state_d   = S_ADC_REQ;
          adc_req_d = 1'b1;
        end
      end
      S_ADC_REQ: begin
        adc_req_d = 1'b0;
        cnt_d     = '0;
        state_d   = S_ADC_WAIT;
      end
      S_ADC_WAIT: begin
        if (bus.i_adc_valid) begin
          actual_d = bus.i_adc_data;
          cnt_d    = '0;
          state_d  = S_SETTLE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          timeout_d = 1'b1;
          cnt_d     = '0;
          state_d   = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_SETTLE: begin
        // Pipeline inputs stay frozen until the capture edge; clear is honoured only there.
        if (cnt_q == CNT_W'(PIPE_LATENCY)) begin
          integral_d = bus.i_integral_clear ? '0 : integ_clamped;
          dac_data_d = dac_sat;
          dac_req_d  = 1'b1;
          cnt_d      = '0;
          state_d    = S_DAC_WAIT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DAC_WAIT: begin
        if (bus.i_dac_ready) begin
          dac_req_d = 1'b0;
          iter_d    = iter_q + 32'd1;
          state_d   = S_IDLE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          timeout_d = 1'b1;
          dac_req_d = 1'b0;
          cnt_d     = '0;
          state_d   = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d   = S_IDLE;
        adc_req_d = 1'b0;
        dac_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      adc_req_q  <= 1'b0;
      actual_q   <= '0;
      integral_q <= '0;
      dac_req_q  <= 1'b0;
      dac_data_q <= '0;
      timeout_q  <= 1'b0;
      iter_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      adc_req_q  <= adc_req_d;
      actual_q   <= actual_d;
      integral_q <= integral_d;
      dac_req_q  <= dac_req_d;
      dac_data_q <= dac_data_d;
      timeout_q  <= timeout_d;
      iter_q     <= iter_d;
    end
  end

  assign bus.o_adc_req       = adc_req_q;
  assign bus.o_pipe_actual   = actual_q;
  assign bus.o_pipe_integral = integral_q;
  assign bus.o_dac_req       = dac_req_q;
  assign bus.o_dac_data      = dac_data_q;
  assign bus.o_busy          = (state_q != S_IDLE);
  assign bus.o_timeout       = timeout_q;
  assign bus.o_iterations    = iter_q;

endmodule

// File: tb/tb_pi_loop_sequencer.sv
// Directed bench for pi_loop_sequencer with OUT_SHIFT=0 and hand-computed expectations.
module tb_pi_loop_sequencer;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  pi_loop_sequencer_if #(.INPUT_WIDTH(18), .OUTPUT_WIDTH(32), .DAC_WIDTH(20)) bus ();

  pi_loop_sequencer #(
    .INPUT_WIDTH (18),
    .OUTPUT_WIDTH(32),
    .DAC_WIDTH   (20),
    .OUT_SHIFT   (0),
    .PIPE_LATENCY(4),
    .INT_LIMIT   (2**30 - 1),
    .TIMEOUT     (1023)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one iteration up to and including the capture edge (E0+5).
  // clr_mode: 0 none, 1 clear on capture edge, 2 clear mid-settle.
  task automatic start_iter(input logic signed [17:0] sample, input logic signed [31:0] integ,
                            input logic signed [31:0] pout, input int clr_mode,
                            input longint int_before);
    bus.i_pipe_integral = integ;
    bus.i_pipe_out      = pout;
    bus.i_enable        = 1'b1;
    tick();
    check_val("adc_req_on", longint'(bus.o_adc_req), 1);
    bus.i_enable = 1'b0;
    tick();
    check_val("adc_req_one_cycle", longint'(bus.o_adc_req), 0);
    bus.i_adc_valid = 1'b1;
    bus.i_adc_data  = sample;
    tick();
    bus.i_adc_valid = 1'b0;
    check_val("pipe_actual", longint'($signed(bus.o_pipe_actual)), longint'(sample));
    check_val("pipe_integral_presented", longint'($signed(bus.o_pipe_integral)), int_before);
    tick();
    if (clr_mode == 2) bus.i_integral_clear = 1'b1;
    tick();
    bus.i_integral_clear = 1'b0;
    if (clr_mode == 2)
      check_val("settle_clear_ignored", longint'($signed(bus.o_pipe_integral)), int_before);
    tick();
    tick();
    check_val("dac_req_not_early", longint'(bus.o_dac_req), 0);
    if (clr_mode == 1) bus.i_integral_clear = 1'b1;
    tick();
    bus.i_integral_clear = 1'b0;
    check_val("dac_req_at_capture", longint'(bus.o_dac_req), 1);
    check_val("busy_at_capture", longint'(bus.o_busy), 1);
  endtask

  task automatic finish_iter(input longint exp_iter);
    bus.i_dac_ready = 1'b1;
    tick();
    bus.i_dac_ready = 1'b0;
    check_val("dac_req_dropped", longint'(bus.o_dac_req), 0);
    check_val("iterations", longint'(bus.o_iterations), exp_iter);
    check_val("idle_after_iter", longint'(bus.o_busy), 0);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    bus.i_enable         = 1'b0;
    bus.i_integral_clear = 1'b0;
    bus.i_adc_valid      = 1'b0;
    bus.i_adc_data       = '0;
    bus.i_pipe_integral  = '0;
    bus.i_pipe_out       = '0;
    bus.i_dac_ready      = 1'b0;
    tick();
    tick();
    check_val("rst_adc_req", longint'(bus.o_adc_req), 0);
    check_val("rst_dac_req", longint'(bus.o_dac_req), 0);
    check_val("rst_busy", longint'(bus.o_busy), 0);
    check_val("rst_timeout", longint'(bus.o_timeout), 0);
    check_val("rst_iterations", longint'(bus.o_iterations), 0);
    check_val("rst_integral", longint'(bus.o_pipe_integral), 0);
    check_val("rst_dac_data", longint'(bus.o_dac_data), 0);
    rst_n = 1'b1;

    // ADC valid while idle must be ignored
    bus.i_adc_valid = 1'b1;
    bus.i_adc_data  = 18'sd55;
    tick();
    bus.i_adc_valid = 1'b0;
    check_val("idle_valid_ignored", longint'(bus.o_pipe_actual), 0);
    check_val("idle_valid_busy", longint'(bus.o_busy), 0);

    // Single pass: sample 100, kp=1 -> output 100
    start_iter(18'sd100, 32'sd0, 32'sd100, 0, 0);
    check_val("single_dac_data", longint'($signed(bus.o_dac_data)), 100);
    check_val("single_integral", longint'($signed(bus.o_pipe_integral)), 0);
    finish_iter(1);

    // Positive integral clamp and positive DAC saturation
    start_iter(-18'sd20, 32'sh7FFF_FFFF, 32'sd33554432, 0, 0);
    check_val("sat_pos_dac", longint'($signed(bus.o_dac_data)), 524287);
    check_val("clamp_pos_integral", longint'($signed(bus.o_pipe_integral)), 1073741823);
    finish_iter(2);

    // Clamped value presented next pass; negative clamp is symmetric
    start_iter(18'sd7, 32'sh8000_0000, -32'sd33554432, 0, 1073741823);
    check_val("sat_neg_dac", longint'($signed(bus.o_dac_data)), -524288);
    check_val("clamp_neg_integral", longint'($signed(bus.o_pipe_integral)), -1073741823);
    finish_iter(3);

    // Clear mid-settle ignored
    start_iter(18'sd1, 32'sd5000, -32'sd3, 2, -1073741823);
    check_val("mid_clear_dac", longint'($signed(bus.o_dac_data)), -3);
    check_val("mid_clear_integral", longint'($signed(bus.o_pipe_integral)), 5000);
    finish_iter(4);

    // Clear in IDLE
    bus.i_integral_clear = 1'b1;
    tick();
    bus.i_integral_clear = 1'b0;
    check_val("idle_clear_integral", longint'($signed(bus.o_pipe_integral)), 0);

    // Clear on capture edge overrides write-back
    start_iter(18'sd2, 32'sd1234, 32'sd8, 1, 0);
    check_val("cap_clear_integral", longint'($signed(bus.o_pipe_integral)), 0);
    check_val("cap_clear_dac", longint'($signed(bus.o_dac_data)), 8);
    finish_iter(5);

    start_iter(18'sd3, 32'sd777, 32'sd0, 0, 0);
    check_val("integral_777", longint'($signed(bus.o_pipe_integral)), 777);
    finish_iter(6);

    // ADC timeout: valid never arrives
    bus.i_pipe_integral = 32'sd55555;
    bus.i_enable = 1'b1;
    tick();
    bus.i_enable = 1'b0;
    tick();
    for (int i = 0; i < 1022; i++) tick();
    check_val("adc_to_not_early", longint'(bus.o_timeout), 0);
    check_val("adc_to_still_busy", longint'(bus.o_busy), 1);
    tick();
    check_val("adc_to_set", longint'(bus.o_timeout), 1);
    check_val("adc_to_idle", longint'(bus.o_busy), 0);
    check_val("adc_to_integral", longint'($signed(bus.o_pipe_integral)), 777);
    check_val("adc_to_iterations", longint'(bus.o_iterations), 6);

    // DAC timeout: ready stuck low
    start_iter(18'sd4, 32'sd999, 32'sd16, 0, 777);
    check_val("dac_to_data", longint'($signed(bus.o_dac_data)), 16);
    for (int i = 0; i < 1022; i++) tick();
    check_val("dac_to_req_held", longint'(bus.o_dac_req), 1);
    tick();
    check_val("dac_to_req_drop", longint'(bus.o_dac_req), 0);
    check_val("dac_to_idle", longint'(bus.o_busy), 0);
    check_val("dac_to_iterations", longint'(bus.o_iterations), 6);
    check_val("dac_to_sticky", longint'(bus.o_timeout), 1);

    // Reset during DAC_WAIT aborts on that edge, even with ready high
    start_iter(18'sd5, 32'sd11, 32'sd12, 0, 999);
    tick();
    check_val("abort_pre_req", longint'(bus.o_dac_req), 1);
    rst_n = 1'b0;
    bus.i_dac_ready = 1'b1;
    tick();
    rst_n = 1'b1;
    bus.i_dac_ready = 1'b0;
    check_val("abort_dac_req", longint'(bus.o_dac_req), 0);
    check_val("abort_iterations", longint'(bus.o_iterations), 0);
    check_val("abort_busy", longint'(bus.o_busy), 0);
    check_val("abort_timeout", longint'(bus.o_timeout), 0);
    check_val("abort_integral", longint'(bus.o_pipe_integral), 0);
    check_val("abort_dac_data", longint'(bus.o_dac_data), 0);
    check_val("abort_actual", longint'(bus.o_pipe_actual), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
